spi_job_loader: RTL and testbench

SPI_JOB_LOADER -- requirements
Module: spi_job_loader

---
 rtl/spi_job_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_job_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_job_loader.sv
// ============================================================================
// spi_job_loader
// ----------------------------------------------------------------------------
// Receives a mining job word over a mode-0 SPI link, which runs on a clock
// unrelated to clk_in, and presents it to a downstream hashing core through a
// valid/ready handshake.
//
// All three SPI inputs are brought into the clk_in domain through 2-flop
// synchronizers. SCK and CS get a third register so that edges can be
// detected. A small control FSM (IDLE -> SHIFT -> COMMIT) frames each
// transfer. At the end of a transfer it decides whether the shift register
// is loaded into the held job word.
//
// Build option:
//   SHAPOOL_JOB_LEN_CHECK_EN
//     Undefined (default): every transfer end commits, regardless of the bit
//     count. A short job is right-aligned and its upper bits are zero.
//     len_err_out is tied low.
//     Defined: a job commits only when exactly JOB_BITS bits arrived.
//     Otherwise the held job is left alone and len_err_out pulses.
//
// CNT_WIDTH must be chosen so that 2**CNT_WIDTH-1 > JOB_BITS. Then a
// saturated counter can never be mistaken for a correct length.
// The SCK rate must be at most one quarter of clk_in so that the synchronizer
// sees every SCK edge.
// ============================================================================
module spi_job_loader #(
    parameter int JOB_BITS  = 352,
    parameter int CNT_WIDTH = 9
) (
    input  logic                clk_in,
    input  logic                reset_n_in,
    input  logic                sck0_in,
    input  logic                sdi0_in,
    input  logic                cs0_n_in,
    output logic [JOB_BITS-1:0] job_data_out,
    output logic                job_valid_out,
    input  logic                job_ready_in,
    output logic                busy_out,
    output logic                overrun_out,
    output logic                len_err_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_JOB = CNT_WIDTH'(JOB_BITS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Synchronizer / edge-detect registers
    // ------------------------------------------------------------------
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic sdi_meta_q, sdi_sync_q;
    logic cs_meta_q,  cs_sync_q,  cs_prev_q;

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    state_e                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [JOB_BITS-1:0]   shift_q;
    logic [JOB_BITS-1:0]   job_data_q;
    logic                  job_valid_q;
    logic                  busy_q;
    logic                  overrun_q;
`ifdef SHAPOOL_JOB_LEN_CHECK_EN
    logic                  len_err_q;
`endif

    // ------------------------------------------------------------------
    // Derived combinational signals
    // ------------------------------------------------------------------
    logic                  sck_rise_s;
    logic                  cs_fall_s;
    logic                  cs_rise_s;
    logic                  consume_s;
    logic                  len_ok_s;
    logic [JOB_BITS-1:0]   shift_d;
    logic [CNT_WIDTH-1:0]  cnt_d;

    // Bring the asynchronous SPI pins into clk_in; the idle levels are sck=0, cs=1.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            sdi_meta_q <= 1'b0;
            sdi_sync_q <= 1'b0;
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_meta_q <= sck0_in;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            sdi_meta_q <= sdi0_in;
            sdi_sync_q <= sdi_meta_q;
            cs_meta_q  <= cs0_n_in;
            cs_sync_q  <= cs_meta_q;
            cs_prev_q  <= cs_sync_q;
        end
    end

    assign sck_rise_s = sck_sync_q & ~sck_prev_q;
    assign cs_fall_s  = ~cs_sync_q & cs_prev_q;
    assign cs_rise_s  = cs_sync_q & ~cs_prev_q;
    assign consume_s  = job_valid_q & job_ready_in;

`ifdef SHAPOOL_JOB_LEN_CHECK_EN
    assign len_ok_s = (cnt_q == CNT_JOB);
`else
    assign len_ok_s = 1'b1;
`endif

    // Next shift-register value and saturating bit count for one captured SCK edge.
    always_comb begin
        shift_d = {shift_q[JOB_BITS-2:0], sdi_sync_q};
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Transfer-framing FSM, together with the shift register, the held job and the handshake flags.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_WIDTH{1'b0}};
            shift_q     <= {JOB_BITS{1'b0}};
            job_data_q  <= {JOB_BITS{1'b0}};
            job_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SHAPOOL_JOB_LEN_CHECK_EN
            len_err_q   <= 1'b0;
`endif
        end else begin
            // Pulses last one cycle unless they are re-armed below.
            overrun_q <= 1'b0;
`ifdef SHAPOOL_JOB_LEN_CHECK_EN
            len_err_q <= 1'b0;
`endif
            // The downstream core takes the job. A commit later in this cycle overrides this.
            if (consume_s) begin
                job_valid_q <= 1'b0;
            end else begin
                job_valid_q <= job_valid_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        cnt_q   <= {CNT_WIDTH{1'b0}};
                        shift_q <= {JOB_BITS{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_SHIFT: begin
                    if (cs_rise_s) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_COMMIT;
                    end else if (sck_rise_s && !cs_sync_q) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_d;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end

                ST_COMMIT: begin
                    if (len_ok_s) begin
                        job_data_q  <= shift_q;
                        job_valid_q <= 1'b1;
                        // Losing an unconsumed job is only an overrun when it is not taken in this same cycle.
                        overrun_q   <= job_valid_q & ~job_ready_in;
                    end else begin
`ifdef SHAPOOL_JOB_LEN_CHECK_EN
                        len_err_q   <= 1'b1;
`endif
                    end
                    // A new transfer may already be starting; take it without dropping back to IDLE.
                    if (cs_fall_s) begin
                        cnt_q   <= {CNT_WIDTH{1'b0}};
                        shift_q <= {JOB_BITS{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign job_data_out  = job_data_q;
    assign job_valid_out = job_valid_q;
    assign busy_out      = busy_q;
    assign overrun_out   = overrun_q;
`ifdef SHAPOOL_JOB_LEN_CHECK_EN
    assign len_err_out   = len_err_q;
`else
    assign len_err_out   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_job_loader.sv
// ============================================================================
// tb_spi_job_loader
// Drives SPI jobs, both directed and random, into spi_job_loader. Every cycle
// it compares the outputs with a job-level reference model. That model keeps
// the received bits as a value, schedules the commit a fixed number of clocks
// after CS rises (2-flop synchronizer + edge register + COMMIT cycle), and
// applies the valid/ready/overrun rules directly. Honours
// SHAPOOL_JOB_LEN_CHECK_EN the same way the design does.
// ============================================================================
module tb_spi_job_loader;

    localparam int JOB_BITS  = 352;
    localparam int CNT_WIDTH = 9;
    localparam int COMMIT_LAT = 4;   // cs pin rise -> job visible: 2 sync + 1 edge + COMMIT
    localparam int BUSY_LAT   = 3;   // cs pin change -> busy_out change

    logic                clk_in = 1'b0;
    logic                reset_n_in = 1'b0;
    logic                sck0_in = 1'b0;
    logic                sdi0_in = 1'b0;
    logic                cs0_n_in = 1'b1;
    logic                job_ready_in = 1'b0;
    logic [JOB_BITS-1:0] job_data_out;
    logic                job_valid_out;
    logic                busy_out;
    logic                overrun_out;
    logic                len_err_out;

    spi_job_loader #(.JOB_BITS(JOB_BITS), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_in        (clk_in),
        .reset_n_in    (reset_n_in),
        .sck0_in       (sck0_in),
        .sdi0_in       (sdi0_in),
        .cs0_n_in      (cs0_n_in),
        .job_data_out  (job_data_out),
        .job_valid_out (job_valid_out),
        .job_ready_in  (job_ready_in),
        .busy_out      (busy_out),
        .overrun_out   (overrun_out),
        .len_err_out   (len_err_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;
    int ovr_seen    = 0;
    int lerr_seen   = 0;
    bit rdy_rand    = 1'b0;

    // ---------------- reference model state ----------------
    logic [JOB_BITS-1:0] m_data  = '0;
    logic                m_valid = 1'b0;
    logic                m_ovr   = 1'b0;
    logic                m_lerr  = 1'b0;
    logic [BUSY_LAT-1:0] cs_hist = '1;
    logic [JOB_BITS-1:0] m_acc   = '0;   // bits of the current transfer, newest in the LSB
    int                  m_cnt   = 0;
    logic [JOB_BITS-1:0] pend_data = '0;
    bit                  pend_ok   = 1'b0;
    int                  pend_cnt  = 0;

    // Reference model, advanced once per clock edge.
    initial begin
        forever begin
            @(posedge clk_in);
            if (!reset_n_in) begin
                m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_lerr = 1'b0;
                cs_hist = '1; pend_cnt = 0;
            end else begin
                bit v0;
                bit commit_now;
                v0 = m_valid;
                m_ovr = 1'b0;
                m_lerr = 1'b0;
                commit_now = 1'b0;
                if (pend_cnt > 0) begin
                    pend_cnt = pend_cnt - 1;
                    if (pend_cnt == 0) commit_now = 1'b1;
                end
                if (v0 && job_ready_in) m_valid = 1'b0;
                if (commit_now) begin
                    if (pend_ok) begin
                        m_data  = pend_data;
                        m_valid = 1'b1;
                        m_ovr   = v0 && !job_ready_in;
                    end else begin
                        m_lerr  = 1'b1;
                    end
                end
                cs_hist = {cs_hist[BUSY_LAT-2:0], cs0_n_in};
            end
        end
    end

    task automatic cmp(input string name, input logic [JOB_BITS-1:0] act, input logic [JOB_BITS-1:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled away from the active edge.
    initial begin
        forever begin
            @(negedge clk_in);
            if (reset_n_in) begin
                cmp("job_data",  job_data_out, m_data);
                cmp("job_valid", {{(JOB_BITS-1){1'b0}}, job_valid_out}, {{(JOB_BITS-1){1'b0}}, m_valid});
                cmp("busy",      {{(JOB_BITS-1){1'b0}}, busy_out},      {{(JOB_BITS-1){1'b0}}, ~cs_hist[BUSY_LAT-1]});
                cmp("overrun",   {{(JOB_BITS-1){1'b0}}, overrun_out},   {{(JOB_BITS-1){1'b0}}, m_ovr});
                cmp("len_err",   {{(JOB_BITS-1){1'b0}}, len_err_out},   {{(JOB_BITS-1){1'b0}}, m_lerr});
                if (overrun_out) ovr_seen = ovr_seen + 1;
                if (len_err_out) lerr_seen = lerr_seen + 1;
            end
        end
    end

    // Random ready generator, active only in the random phase.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (rdy_rand) job_ready_in = ($urandom_range(0, 3) == 0);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Send nbits of d (d[nbits-1] first). With end_xfer set, finish the frame and schedule the model commit.
    task automatic spi_job(input int nbits, input int half, input logic [511:0] d, input bit end_xfer);
        cs0_n_in = 1'b0;
        m_acc = '0;
        m_cnt = 0;
        repeat (3) tick();
        for (int i = 0; i < nbits; i++) begin
            sdi0_in = d[nbits-1-i];
            sck0_in = 1'b0;
            repeat (half) tick();
            sck0_in = 1'b1;
            m_acc = {m_acc[JOB_BITS-2:0], d[nbits-1-i]};
            m_cnt = m_cnt + 1;
            repeat (half) tick();
        end
        sck0_in = 1'b0;
        repeat (3) tick();
        if (end_xfer) begin
            cs0_n_in = 1'b1;
            pend_data = m_acc;
`ifdef SHAPOOL_JOB_LEN_CHECK_EN
            pend_ok = (m_cnt == JOB_BITS);
`else
            pend_ok = 1'b1;
`endif
            pend_cnt = COMMIT_LAT;
        end
    endtask

    logic [511:0]        pat;
    logic [JOB_BITS-1:0] exp_v;

    initial begin
        repeat (3) tick();
        reset_n_in = 1'b1;
        repeat (3) tick();
        cmp("reset_valid", {{(JOB_BITS-1){1'b0}}, job_valid_out}, '0);
        cmp("reset_data", job_data_out, '0);

        // 0xA5 job at 8:1 with ready low
        ovr_seen = 0; lerr_seen = 0;
        pat = {64{8'hA5}};
        spi_job(JOB_BITS, 4, pat, 1'b1);
        repeat (8) tick();
        exp_v = {44{8'hA5}};
        cmp("a5_data", job_data_out, exp_v);
        cmp("a5_valid", {{(JOB_BITS-1){1'b0}}, job_valid_out}, {{(JOB_BITS-1){1'b0}}, 1'b1});
        cmp("a5_no_pulses", JOB_BITS'(ovr_seen + lerr_seen), '0);

        // all-ones job over an unconsumed one: overrun
        ovr_seen = 0;
        pat = '1;
        spi_job(JOB_BITS, 2, pat, 1'b1);
        repeat (8) tick();
        cmp("ones_data", job_data_out, {JOB_BITS{1'b1}});
        cmp("ones_ovr_pulses", JOB_BITS'(ovr_seen), JOB_BITS'(1));
        cmp("ones_valid", {{(JOB_BITS-1){1'b0}}, job_valid_out}, {{(JOB_BITS-1){1'b0}}, 1'b1});

        // ready asserted exactly in the commit cycle of the next job
        ovr_seen = 0;
        pat = {64{8'h3C}};
        spi_job(JOB_BITS, 2, pat, 1'b1);
        repeat (COMMIT_LAT - 1) tick();
        job_ready_in = 1'b1;
        tick();
        job_ready_in = 1'b0;
        repeat (6) tick();
        exp_v = {44{8'h3C}};
        cmp("same_cycle_data", job_data_out, exp_v);
        cmp("same_cycle_valid", {{(JOB_BITS-1){1'b0}}, job_valid_out}, {{(JOB_BITS-1){1'b0}}, 1'b1});
        cmp("same_cycle_no_ovr", JOB_BITS'(ovr_seen), '0);

        // 351-bit transfer
        lerr_seen = 0;
        pat = '1;
        spi_job(JOB_BITS - 1, 2, pat, 1'b1);
        repeat (8) tick();
`ifdef SHAPOOL_JOB_LEN_CHECK_EN
        cmp("short_len_err", JOB_BITS'(lerr_seen), JOB_BITS'(1));
        exp_v = {44{8'h3C}};
        cmp("short_data_kept", job_data_out, exp_v);
`else
        exp_v = {JOB_BITS{1'b1}} >> 1;
        cmp("short_data", job_data_out, exp_v);
        cmp("short_len_err", JOB_BITS'(lerr_seen), '0);
`endif

        // reset in the middle of a transfer, then a full job
        pat = {16{32'hDEADBEEF}};
        spi_job(100, 2, pat, 1'b0);
        reset_n_in = 1'b0;
        cs0_n_in = 1'b1;
        sck0_in = 1'b0;
        repeat (3) tick();
        reset_n_in = 1'b1;
        repeat (5) tick();
        cmp("post_reset_valid", {{(JOB_BITS-1){1'b0}}, job_valid_out}, '0);
        spi_job(JOB_BITS, 2, pat, 1'b1);
        repeat (8) tick();
        exp_v = {11{32'hDEADBEEF}};
        cmp("post_reset_data", job_data_out, exp_v);
        cmp("post_reset_valid2", {{(JOB_BITS-1){1'b0}}, job_valid_out}, {{(JOB_BITS-1){1'b0}}, 1'b1});

        // sck toggling with cs high, then an empty frame
        lerr_seen = 0;
        for (int i = 0; i < 50; i++) begin
            sck0_in = 1'b1; repeat (2) tick();
            sck0_in = 1'b0; repeat (2) tick();
        end
        spi_job(0, 2, pat, 1'b1);
        repeat (8) tick();
`ifdef SHAPOOL_JOB_LEN_CHECK_EN
        cmp("empty_len_err", JOB_BITS'(lerr_seen), JOB_BITS'(1));
        exp_v = {11{32'hDEADBEEF}};
        cmp("empty_data_kept", job_data_out, exp_v);
`else
        cmp("empty_data", job_data_out, '0);
        cmp("empty_valid", {{(JOB_BITS-1){1'b0}}, job_valid_out}, {{(JOB_BITS-1){1'b0}}, 1'b1});
`endif

        // random phase
        rdy_rand = 1'b1;
        for (int j = 0; j < 14; j++) begin
            int r;
            int nb;
            for (int w = 0; w < 16; w++) pat[w*32 +: 32] = $urandom();
            r = $urandom_range(0, 9);
            if (r == 0)      nb = JOB_BITS - 1;
            else if (r == 1) nb = JOB_BITS + 1 + $urandom_range(0, 20);
            else if (r == 2) nb = $urandom_range(0, 40);
            else             nb = JOB_BITS;
            spi_job(nb, $urandom_range(2, 3), pat, 1'b1);
            repeat ($urandom_range(1, 5)) tick();
        end
        repeat (12) tick();
        rdy_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
